// File: rtl/tile_load_pkg.sv
// Shared state encoding and size helpers for the tile loader.
// Sizes are derived from the word and element widths so every file agrees on them.
package tile_load_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_IFM,
        S_LD_WGT,
        S_LD_BIAS,
        S_HOLD
    } state_t;

    function automatic int calc_lanes(input int in_w, input int elem_w);
        return in_w / elem_w;
    endfunction

    function automatic int calc_nwords(input int nelem, input int lanes);
        return (nelem + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/tile_unpack.sv
// Combinational lane scatter: writes the lanes of one packed word into an element array.
// Elements outside the addressed word pass through from the base array; pad lanes are dropped.
module tile_unpack
    import tile_load_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int ELEM_W = 8,
    parameter int NELEM  = 9,
    parameter int CNT_W  = 2
) (
    input  logic [IN_W-1:0]         i_word,
    input  logic [CNT_W-1:0]        i_idx,
    input  logic [NELEM*ELEM_W-1:0] i_base,
    output logic [NELEM*ELEM_W-1:0] o_elems
);

    localparam int LANES = calc_lanes(IN_W, ELEM_W);

    always_comb begin
        o_elems = i_base;
        for (int e = 0; e < NELEM; e++) begin
            if (i_idx == CNT_W'(e / LANES)) begin
                o_elems[e*ELEM_W +: ELEM_W] = i_word[(e % LANES)*ELEM_W +: ELEM_W];
            end
        end
    end

endmodule

// File: rtl/tile_load_ctrl.sv
// Loads IFM window, weights and bias from a packed word stream into staging, then hands the tile
// to a registered output bank; output visible the edge the last word lands, HOLD stalls input while the bank is full.
module tile_load_ctrl
    import tile_load_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int ELEM_W = 8,
    parameter int KSIZE  = 3,
    parameter int BIAS_W = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  wgt_reuse,
    input  logic [IN_W-1:0]                       in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic signed [KSIZE*KSIZE*ELEM_W-1:0]  ifm_out,
    output logic signed [KSIZE*KSIZE*ELEM_W-1:0]  wgt_out,
    output logic signed [BIAS_W-1:0]              bias_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy
);

    localparam int NELEM  = KSIZE * KSIZE;
    localparam int LANES  = calc_lanes(IN_W, ELEM_W);
    localparam int NWORDS = calc_nwords(NELEM, LANES);
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int VEC_W  = NELEM * ELEM_W;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_reuse;
    logic               r_wgt_loaded;
    logic               r_in_ready;
    logic               r_busy;
    logic [VEC_W-1:0]   r_stg_ifm;
    logic [VEC_W-1:0]   r_stg_wgt;
    logic [BIAS_W-1:0]  r_stg_bias;
    logic [VEC_W-1:0]   r_ifm;
    logic [VEC_W-1:0]   r_wgt;
    logic [BIAS_W-1:0]  r_bias;
    logic               r_out_valid;

    logic               w_acc;
    logic               w_last;
    logic               w_bank_free;
    logic               w_tile_end;
    logic               w_xfer;
    logic [VEC_W-1:0]   w_ifm_unp;
    logic [VEC_W-1:0]   w_wgt_unp;
    logic [VEC_W-1:0]   w_stg_ifm_d;
    logic [VEC_W-1:0]   w_stg_wgt_d;
    logic [BIAS_W-1:0]  w_stg_bias_d;

    assign w_acc       = in_valid && r_in_ready;
    assign w_last      = (r_cnt == CNT_W'(NWORDS - 1));
    assign w_bank_free = !r_out_valid || out_ready;
    assign w_tile_end  = w_acc && ((r_state == S_LD_BIAS) ||
                         (r_state == S_LD_IFM && w_last && r_reuse && r_wgt_loaded));
    assign w_xfer      = (w_tile_end || r_state == S_HOLD) && w_bank_free;

    tile_unpack #(.IN_W(IN_W), .ELEM_W(ELEM_W), .NELEM(NELEM), .CNT_W(CNT_W)) u_unpack_ifm (
        .i_word  (in_data),
        .i_idx   (r_cnt),
        .i_base  (r_stg_ifm),
        .o_elems (w_ifm_unp)
    );

    tile_unpack #(.IN_W(IN_W), .ELEM_W(ELEM_W), .NELEM(NELEM), .CNT_W(CNT_W)) u_unpack_wgt (
        .i_word  (in_data),
        .i_idx   (r_cnt),
        .i_base  (r_stg_wgt),
        .o_elems (w_wgt_unp)
    );

    // Next staging contents; the transfer copies these so the final word reaches the output bank directly.
    assign w_stg_ifm_d  = (w_acc && r_state == S_LD_IFM)  ? w_ifm_unp : r_stg_ifm;
    assign w_stg_wgt_d  = (w_acc && r_state == S_LD_WGT)  ? w_wgt_unp : r_stg_wgt;
    assign w_stg_bias_d = (w_acc && r_state == S_LD_BIAS) ? in_data[BIAS_W-1:0] : r_stg_bias;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_reuse    <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_xfer) begin
            r_cnt <= '0;
            if (enable) begin
                r_state    <= S_LD_IFM;
                r_reuse    <= wgt_reuse;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b1;
            end else begin
                r_state    <= S_IDLE;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b0;
            end
        end else if (w_tile_end) begin
            r_state    <= S_HOLD;
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state    <= S_LD_IFM;
                        r_cnt      <= '0;
                        r_reuse    <= wgt_reuse;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LD_IFM: begin
                    if (w_acc) begin
                        if (w_last) begin
                            r_state <= S_LD_WGT;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LD_WGT: begin
                    if (w_acc) begin
                        if (w_last) begin
                            r_state <= S_LD_BIAS;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_ifm    <= '0;
            r_stg_wgt    <= '0;
            r_stg_bias   <= '0;
            r_wgt_loaded <= 1'b0;
        end else begin
            r_stg_ifm  <= w_stg_ifm_d;
            r_stg_wgt  <= w_stg_wgt_d;
            r_stg_bias <= w_stg_bias_d;
            if (w_acc && r_state == S_LD_BIAS) begin
                r_wgt_loaded <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifm       <= '0;
            r_wgt       <= '0;
            r_bias      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_ifm       <= w_stg_ifm_d;
            r_wgt       <= w_stg_wgt_d;
            r_bias      <= w_stg_bias_d;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign ifm_out   = r_ifm;
    assign wgt_out   = r_wgt;
    assign bias_out  = r_bias;

endmodule
